// File: rtl/regfile_write_demux.sv
// Register-file write demux: buffers write-back requests in a small FIFO and issues one
// one-hot write pulse per cycle. Optional macro WB_BYPASS_EN adds the q_data forwarding port.
module regfile_write_demux #(
  parameter int DEPTH     = 2,
  parameter bit ZERO_DROP = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [4:0]                 wr_addr,
  input  logic [31:0]                wr_data,
  input  logic                       wb_stall,
  output logic [31:0]                we_onehot,
  output logic [4:0]                 wb_addr,
  output logic [31:0]                wb_data,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [4:0]                 q_addr,
  output logic                       q_hit
`ifdef WB_BYPASS_EN
  ,
  output logic [31:0]                q_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [4:0]       mem_addr [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             enq;
  logic             pop;

  // wr_ready is forced low while reset is held, even though count already reads 0.
  assign wr_ready = reset_n && (count < DEPTH_CNT);
  assign push_ok  = wr_valid && wr_ready;
  assign enq      = push_ok && !(ZERO_DROP && (wr_addr == 5'd0));
  assign pop      = (count != '0) && !wb_stall;

  // NOTE: FIFO storage is deliberately not reset; entry validity comes only from count and rd_ptr.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem_addr[wr_ptr] <= wr_addr;
      mem_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      we_onehot <= '0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop) begin
        we_onehot <= 32'd1 << mem_addr[rd_ptr];
        wb_addr   <= mem_addr[rd_ptr];
        wb_data   <= mem_data[rd_ptr];
      end else begin
        we_onehot <= '0;
      end
    end
  end

  // Hazard query: scan live entries oldest to youngest so the youngest match wins.
  logic             fifo_hit;
  logic             issue_hit;
  logic [PTR_W-1:0] idx;

  always_comb begin
    fifo_hit = 1'b0;
    idx      = '0;
`ifdef WB_BYPASS_EN
    q_data   = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((CW'(k) < count) && (mem_addr[idx] == q_addr)) begin
        fifo_hit = 1'b1;
`ifdef WB_BYPASS_EN
        q_data   = mem_data[idx];
`endif
      end
    end
    issue_hit = (we_onehot != '0) && (wb_addr == q_addr);
`ifdef WB_BYPASS_EN
    if (!fifo_hit && issue_hit) q_data = wb_data;
`endif
    q_hit = (q_addr != 5'd0) && (fifo_hit || issue_hit);
  end

endmodule
